// File: rtl/sig_sync_filter_if.sv
// Pad-side signal bundle for sig_sync_filter: the raw line and debug clear in,
// the cleaned level and glitch statistics out.
interface sig_sync_filter_if #(
    parameter int GLITCH_CNT_WIDTH = 8
);
    logic                        async_sig;
    logic                        clear_glitch_cnt;
    logic                        filtered_sig;
    logic                        glitch_pulse;
    logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt;

    // Driver side: supplies the pad line and clear, consumes the filtered outputs.
    modport master (
        output async_sig,
        output clear_glitch_cnt,
        input  filtered_sig,
        input  glitch_pulse,
        input  glitch_cnt
    );

    // Filter side.
    modport slave (
        input  async_sig,
        input  clear_glitch_cnt,
        output filtered_sig,
        output glitch_pulse,
        output glitch_cnt
    );
endinterface

// File: rtl/sig_sync_filter.sv
// Input conditioning for an external pad line: flop-chain synchronizer followed
// by a persistence filter that only accepts a new level after it has been seen
// for STABLE_CYCLES consecutive clocks. Rejected pulses are strobed and counted.
module sig_sync_filter #(
    parameter int SYNC_STAGES      = 2,
    parameter int STABLE_CYCLES    = 4,
    parameter bit RESET_LEVEL      = 1'b1,
    parameter int GLITCH_CNT_WIDTH = 8
) (
    input  logic                sys_clk,
    input  logic                n_reset,
    sig_sync_filter_if.slave    bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    // Count value at which the next differing sample completes qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0]      sync_reg;
    logic                        sync_out;
    state_t                      state_reg,  state_next;
    logic [CNT_W-1:0]            cnt_reg,    cnt_next;
    logic                        filt_reg,   filt_next;
    logic                        pulse_reg;
    logic                        glitch;
    logic [GLITCH_CNT_WIDTH-1:0] gcnt_reg,   gcnt_next;

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // Synchronizer chain: plain flop-to-flop shift, stage 0 samples the pad.
    always_ff @(posedge sys_clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.async_sig};
        end
    end

    // Filter decision: qualify a differing level or flag its early reversion.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        filt_next  = filt_reg;
        glitch     = 1'b0;
        case (state_reg)
            ST_STABLE: begin
                if (sync_out != filt_reg) begin
                    if (STABLE_CYCLES == 1) begin
                        // Single-cycle persistence: accept on first sight.
                        filt_next = sync_out;
                    end else begin
                        state_next = ST_QUALIFY;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (sync_out == filt_reg) begin
                    // Line went back before it was trusted: a glitch.
                    glitch     = 1'b1;
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    filt_next  = ~filt_reg;
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Glitch counter: clear has priority, otherwise saturating increment.
    always_comb begin
        gcnt_next = gcnt_reg;
        if (bus.clear_glitch_cnt) begin
            gcnt_next = '0;
        end else if (glitch && (gcnt_reg != {GLITCH_CNT_WIDTH{1'b1}})) begin
            gcnt_next = gcnt_reg + GLITCH_CNT_WIDTH'(1);
        end
    end

    // Filter state, registered output level, strobe and counter.
    always_ff @(posedge sys_clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= ST_STABLE;
            cnt_reg   <= '0;
            filt_reg  <= RESET_LEVEL;
            pulse_reg <= 1'b0;
            gcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            filt_reg  <= filt_next;
            pulse_reg <= glitch;
            gcnt_reg  <= gcnt_next;
        end
    end

    assign bus.filtered_sig = filt_reg;
    assign bus.glitch_pulse = pulse_reg;
    assign bus.glitch_cnt   = gcnt_reg;

endmodule

// File: tb/tb_sig_sync_filter.sv
// Three filter configurations driven by one shared pad stimulus and checked
// every clock against a run-length reference model of the filtering rules.
//   inst 0: SYNC_STAGES=2, STABLE_CYCLES=4, 8-bit counter (defaults)
//   inst 1: SYNC_STAGES=2, STABLE_CYCLES=4, 2-bit counter (saturation)
//   inst 2: SYNC_STAGES=3, STABLE_CYCLES=1, 8-bit counter (no filtering)
module tb_sig_sync_filter;
    localparam int SS_P  [3] = '{2, 2, 3};
    localparam int SC_P  [3] = '{4, 4, 1};
    localparam int MAX_P [3] = '{255, 3, 255};
    localparam bit RL        = 1'b1;

    logic sys_clk = 1'b0;
    logic n_reset;
    logic async_sig;
    logic clr;

    always #5 sys_clk = ~sys_clk;

    sig_sync_filter_if #(.GLITCH_CNT_WIDTH(8)) if0 ();
    sig_sync_filter_if #(.GLITCH_CNT_WIDTH(2)) if1 ();
    sig_sync_filter_if #(.GLITCH_CNT_WIDTH(8)) if2 ();

    assign if0.async_sig = async_sig;
    assign if1.async_sig = async_sig;
    assign if2.async_sig = async_sig;
    assign if0.clear_glitch_cnt = clr;
    assign if1.clear_glitch_cnt = clr;
    assign if2.clear_glitch_cnt = clr;

    sig_sync_filter #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b1), .GLITCH_CNT_WIDTH(8))
        u_dut0 (.sys_clk(sys_clk), .n_reset(n_reset), .bus(if0.slave));
    sig_sync_filter #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b1), .GLITCH_CNT_WIDTH(2))
        u_dut1 (.sys_clk(sys_clk), .n_reset(n_reset), .bus(if1.slave));
    sig_sync_filter #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .RESET_LEVEL(1'b1), .GLITCH_CNT_WIDTH(8))
        u_dut2 (.sys_clk(sys_clk), .n_reset(n_reset), .bus(if2.slave));

    logic       obs_filt  [3];
    logic       obs_pulse [3];
    logic [7:0] obs_gcnt  [3];
    assign obs_filt[0]  = if0.filtered_sig;
    assign obs_filt[1]  = if1.filtered_sig;
    assign obs_filt[2]  = if2.filtered_sig;
    assign obs_pulse[0] = if0.glitch_pulse;
    assign obs_pulse[1] = if1.glitch_pulse;
    assign obs_pulse[2] = if2.glitch_pulse;
    assign obs_gcnt[0]  = if0.glitch_cnt;
    assign obs_gcnt[1]  = {6'b0, if1.glitch_cnt};
    assign obs_gcnt[2]  = if2.glitch_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: pad samples since reset, plus per-instance run length
    // of consecutive clocks the synchronized level has differed from the output.
    bit alog [$];
    bit m_filt  [3];
    bit m_pulse [3];
    int m_run   [3];
    int m_gcnt  [3];

    // Per-transaction statistics.
    int p_glitch    [3];
    int p_low       [3];
    int p_first_low [3];
    int p_edge;

    task automatic model_reset();
        alog.delete();
        for (int i = 0; i < 3; i++) begin
            m_filt[i]  = RL;
            m_pulse[i] = 1'b0;
            m_run[i]   = 0;
            m_gcnt[i]  = 0;
        end
    endtask

    // Level visible at the synchronizer output just before the next edge:
    // the pad sample taken ss edges ago, or the reset level if none yet.
    function automatic bit sync_seen(int ss);
        if (alog.size() >= ss) return alog[alog.size() - ss];
        return RL;
    endfunction

    task automatic model_edge(input bit a, input bit c);
        bit s;
        for (int i = 0; i < 3; i++) begin
            s = sync_seen(SS_P[i]);
            m_pulse[i] = 1'b0;
            if (s != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] >= SC_P[i]) begin
                    m_filt[i] = s;
                    m_run[i]  = 0;
                end
            end else begin
                m_pulse[i] = (m_run[i] > 0);
                m_run[i]   = 0;
            end
            if (c) m_gcnt[i] = 0;
            else if (m_pulse[i] && m_gcnt[i] < MAX_P[i]) m_gcnt[i]++;
        end
        alog.push_back(a);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            assert (obs_filt[i] === m_filt[i]) else begin
                n_fail++;
                $error("FAIL %s filtered_sig[%0d] observed=%b expected=%b", tag, i, obs_filt[i], m_filt[i]);
            end
            n_assert++;
            assert (obs_pulse[i] === m_pulse[i]) else begin
                n_fail++;
                $error("FAIL %s glitch_pulse[%0d] observed=%b expected=%b", tag, i, obs_pulse[i], m_pulse[i]);
            end
            n_assert++;
            assert (obs_gcnt[i] === 8'(m_gcnt[i])) else begin
                n_fail++;
                $error("FAIL %s glitch_cnt[%0d] observed=%0d expected=%0d", tag, i, obs_gcnt[i], m_gcnt[i]);
            end
        end
    endtask

    task automatic stats_clear();
        for (int i = 0; i < 3; i++) begin
            p_glitch[i]    = 0;
            p_low[i]       = 0;
            p_first_low[i] = -1;
        end
        p_edge = 0;
    endtask

    // One clock: apply inputs, advance model at the edge, compare 1 time unit later.
    task automatic step(input logic a, input logic c);
        async_sig = a;
        clr       = c;
        @(posedge sys_clk);
        model_edge(a, c);
        #1;
        check_all("step");
        for (int i = 0; i < 3; i++) begin
            if (obs_pulse[i] === 1'b1) p_glitch[i]++;
            if (obs_filt[i] === 1'b0) begin
                p_low[i]++;
                if (p_first_low[i] < 0) p_first_low[i] = p_edge;
            end
        end
        p_edge++;
    endtask

    task automatic segment(input logic lvl, input int len, input bit rclr);
        for (int e = 0; e < len; e++) begin
            step(lvl, rclr ? ($urandom_range(0, 15) == 0) : 1'b0);
        end
    endtask

    // Low pulse of width w on an idle-high line, then hold high.
    task automatic low_pulse(input int w, input int hold, input string name);
        stats_clear();
        segment(1'b0, w, 1'b0);
        segment(1'b1, hold, 1'b0);
        $display("txn %s: low width=%0d glitches=%0d/%0d/%0d low_cycles=%0d/%0d/%0d cnt=%0d/%0d/%0d",
                 name, w, p_glitch[0], p_glitch[1], p_glitch[2], p_low[0], p_low[1], p_low[2],
                 obs_gcnt[0], obs_gcnt[1], obs_gcnt[2]);
    endtask

    initial begin
        int lat0;
        int lat2;
        logic lvl;
        int len;

        // Reset held with the pad low: outputs sit at the idle-high reset level.
        n_reset   = 1'b0;
        async_sig = 1'b0;
        clr       = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check_all("reset_hold");
        chk("reset_filt0", {7'b0, obs_filt[0]}, 8'd1);
        chk("reset_cnt0", obs_gcnt[0], 8'd0);
        $display("txn reset_hold: filt=%b/%b/%b", obs_filt[0], obs_filt[1], obs_filt[2]);

        // Release and let the low level get two clocks into qualification.
        n_reset = 1'b1;
        stats_clear();
        segment(1'b0, 4, 1'b0);
        // Asynchronous reset between edges, with no clock edge before checking.
        #2;
        n_reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_filt2", {7'b0, obs_filt[2]}, 8'd1);
        $display("txn async_reset_mid_qualify: filt=%b/%b/%b", obs_filt[0], obs_filt[1], obs_filt[2]);
        repeat (2) begin
            @(posedge sys_clk);
            #1;
            check_all("in_reset");
        end

        // Release again: the low level must requalify from scratch.
        n_reset = 1'b1;
        stats_clear();
        segment(1'b0, 12, 1'b0);
        lat0 = p_first_low[0];
        lat2 = p_first_low[2];
        chk("latency_default", 8'(lat0), 8'd5);
        chk("latency_ss3_sc1", 8'(lat2), 8'd3);
        chk("clean_edge_no_glitch", 8'(p_glitch[0]), 8'd0);
        $display("txn release_latency: clocks_after_capture=%0d/%0d", lat0, lat2);

        // Clean rising edge back to idle.
        stats_clear();
        segment(1'b1, 20, 1'b0);
        chk("rise_no_glitch", 8'(p_glitch[0]), 8'd0);
        chk("rise_filt0", {7'b0, obs_filt[0]}, 8'd1);
        $display("txn clean_rise: filt=%b/%b/%b", obs_filt[0], obs_filt[1], obs_filt[2]);

        // Filter threshold: one clock short is rejected, exactly enough is accepted.
        low_pulse(3, 10, "pulse3");
        chk("pulse3_glitches", 8'(p_glitch[0]), 8'd1);
        chk("pulse3_low", 8'(p_low[0]), 8'd0);
        chk("pulse3_cnt", obs_gcnt[0], 8'd1);
        chk("pulse3_replica", 8'(p_low[2]), 8'd3);

        low_pulse(4, 10, "pulse4");
        chk("pulse4_low", 8'(p_low[0]), 8'd4);
        chk("pulse4_glitches", 8'(p_glitch[0]), 8'd0);
        chk("pulse4_cnt", obs_gcnt[0], 8'd1);

        // Single-clock pulse through the unfiltered 3-stage instance.
        low_pulse(1, 10, "pulse1");
        chk("pulse1_replica_low", 8'(p_low[2]), 8'd1);
        chk("pulse1_replica_delay", 8'(p_first_low[2]), 8'd3);
        chk("pulse1_sc1_cnt", obs_gcnt[2], 8'd0);

        // Saturation: clear, then five rejected glitches into a 2-bit counter.
        step(1'b1, 1'b1);
        chk("clear_cnt1", obs_gcnt[1], 8'd0);
        len = 0;
        for (int g = 0; g < 5; g++) begin
            low_pulse(2, 6, "sat_glitch");
            len += p_glitch[1];
        end
        chk("sat_pulses", 8'(len), 8'd5);
        chk("sat_cnt", obs_gcnt[1], 8'd3);

        // Sixth glitch with clear on the very edge that rejects it.
        stats_clear();
        segment(1'b0, 3, 1'b0);
        segment(1'b1, 2, 1'b0);
        step(1'b1, 1'b1);
        chk("clr_glitch_pulse", {7'b0, obs_pulse[1]}, 8'd1);
        chk("clr_glitch_cnt", obs_gcnt[1], 8'd0);
        segment(1'b1, 6, 1'b0);
        $display("txn clear_with_glitch: pulse_seen=%0d cnt=%0d", p_glitch[1], obs_gcnt[1]);

        // Random segments with occasional clears, checked every clock by the model.
        lvl = 1'b0;
        for (int t = 0; t < 60; t++) begin
            len = int'($urandom_range(1, 7));
            stats_clear();
            segment(lvl, len, 1'b1);
            $display("txn random %0d: level=%b len=%0d filt=%b/%b/%b cnt=%0d/%0d/%0d", t, lvl, len,
                     obs_filt[0], obs_filt[1], obs_filt[2], obs_gcnt[0], obs_gcnt[1], obs_gcnt[2]);
            lvl = ~lvl;
        end
        segment(1'b1, 10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
